// File: rtl/vtopk_pkg.sv
// Shared types for the vector top-K engine: FSM states, score/id widths, list entry.
package vtopk_pkg;

  localparam int unsigned SCORE_W = 32;
  localparam int unsigned ID_W    = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_INSERT = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef struct packed {
    logic signed [SCORE_W-1:0] score;
    logic [ID_W-1:0]           id;
  } entry_t;

endpackage

// File: rtl/vtopk_insert.sv
// Combinational K-slot shift-insert into a descending score list.
// Equal scores keep the incumbent ahead, so earlier ids win ties.
module vtopk_insert
  import vtopk_pkg::*;
#(
  parameter int unsigned K = 4
) (
  input  entry_t [K-1:0] i_list,
  input  logic [2:0]     i_count,
  input  entry_t         i_new,
  input  logic           i_en,
  output entry_t [K-1:0] o_list,
  output logic [2:0]     o_count
);

  int unsigned w_pos;

  // Rank = number of filled slots scoring >= the new entry; shift the tail down by one.
  always_comb begin
    w_pos   = 0;
    o_list  = i_list;
    o_count = i_count;
    for (int unsigned i = 0; i < K; i++) begin
      if (i < 32'(i_count) && ($signed(i_list[i].score) >= $signed(i_new.score))) begin
        w_pos = w_pos + 1;
      end
    end
    if (i_en && (w_pos < K)) begin
      if (w_pos == 0) o_list[0] = i_new;
      for (int unsigned i = 1; i < K; i++) begin
        if (i > w_pos) begin
          o_list[i] = i_list[i-1];
        end else if (i == w_pos) begin
          o_list[i] = i_new;
        end
      end
      if (32'(i_count) < K) o_count = i_count + 3'd1;
    end
  end

endmodule

// File: rtl/vector_topk_engine.sv
// Scans int8 vectors in memory, scores each against a query buffer by dot product,
// and keeps the K best (score, id) pairs. Optional macro VTOPK_THRESHOLD_EN adds
// a min_score input below which scores are not inserted.
module vector_topk_engine
  import vtopk_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned K      = 4,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned QWORDS = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    start_search,
  input  logic [9:0]              vector_count,
  input  logic [7:0]              dim_size,
  input  logic [ADDR_W-1:0]       vec_stride,
  input  logic                    q_wr_en,
  input  logic [5:0]              q_wr_addr,
  input  logic [8*LANES-1:0]      q_wr_data,
`ifdef VTOPK_THRESHOLD_EN
  input  logic signed [31:0]      min_score,
`endif
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [8*LANES-1:0]      mem_data,
  output logic [32*K-1:0]         topk_score,
  output logic [10*K-1:0]         topk_id,
  output logic [2:0]              topk_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned WORD_W = 8 * LANES;
  localparam int unsigned QIDX_W = (QWORDS > 1) ? $clog2(QWORDS) : 1;
  localparam int unsigned WCNT_W = 9;

  state_t                    r_state, w_state_nxt;
  logic                      r_busy, w_busy_nxt;
  logic                      r_done, w_done_nxt;
  logic [9:0]                r_count;
  logic [7:0]                r_dim;
  logic [ADDR_W-1:0]         r_stride;
  logic [ADDR_W-1:0]         r_base;
  logic [ADDR_W-1:0]         r_mem_addr;
  logic [WCNT_W-1:0]         r_widx;
  logic [WCNT_W-1:0]         w_words;
  logic [WCNT_W-1:0]         w_didx;
  logic [9:0]                r_vid;
  logic signed [31:0]        r_acc;
  logic signed [31:0]        w_word_sum;
  logic signed [15:0]        w_a, w_b, w_p;
  logic [WORD_W-1:0]         r_query [QWORDS];
  logic [WORD_W-1:0]         w_qword;
  entry_t [K-1:0]            r_list, w_list_ins;
  logic [2:0]                r_valid, w_valid_ins;
  entry_t                    w_new;
  logic                      w_keep;
  logic                      w_start;

  assign w_start = (r_state == ST_IDLE) && start_search && !clear;
  assign w_didx  = r_widx - WCNT_W'(1);
  assign w_qword = r_query[QIDX_W'(w_didx)];

  // Words per vector: ceil(dim/LANES), with an empty vector still costing one word.
  always_comb begin
    w_words = WCNT_W'(1);
    if (r_dim != 8'd0) w_words = WCNT_W'((32'(r_dim) + LANES - 1) / LANES);
  end

  // Dot product of the returning memory word with the matching query word, masking lanes past dim.
  always_comb begin
    w_word_sum = '0;
    w_a        = '0;
    w_b        = '0;
    w_p        = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      w_a = {{8{mem_data[8*l+7]}}, mem_data[8*l +: 8]};
      w_b = {{8{w_qword[8*l+7]}}, w_qword[8*l +: 8]};
      w_p = w_a * w_b;
      if (32'(w_didx) * LANES + l < 32'(r_dim)) begin
        w_word_sum = w_word_sum + {{16{w_p[15]}}, w_p};
      end
    end
  end

`ifdef VTOPK_THRESHOLD_EN
  assign w_keep = (r_acc >= min_score);
`else
  assign w_keep = 1'b1;
`endif

  always_comb begin
    w_new       = '0;
    w_new.score = r_acc;
    w_new.id    = r_vid;
  end

  vtopk_insert #(.K(K)) u_insert (
    .i_list  (r_list),
    .i_count (r_valid),
    .i_new   (w_new),
    .i_en    (w_keep),
    .o_list  (w_list_ins),
    .o_count (w_valid_ins)
  );

  // FSM state and registered busy/done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next state and next busy/done; clear wins over everything.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start_search) w_state_nxt = (vector_count == 10'd0) ? ST_DONE : ST_FETCH;
      ST_FETCH:  if (r_widx == w_words - WCNT_W'(1)) w_state_nxt = ST_DRAIN;
      ST_DRAIN:  w_state_nxt = ST_INSERT;
      ST_INSERT: w_state_nxt = (r_vid == r_count - 10'd1) ? ST_DONE : ST_FETCH;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (clear) w_state_nxt = ST_IDLE;
    w_busy_nxt = (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_DRAIN) ||
                 (w_state_nxt == ST_INSERT);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  // Search datapath: config latch, address generation, accumulation, list update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count    <= '0;
      r_dim      <= '0;
      r_stride   <= '0;
      r_base     <= '0;
      r_mem_addr <= '0;
      r_widx     <= '0;
      r_vid      <= '0;
      r_acc      <= '0;
      r_list     <= '0;
      r_valid    <= '0;
    end else if (clear) begin
      r_list  <= '0;
      r_valid <= '0;
    end else if (w_start) begin
      r_count    <= vector_count;
      r_dim      <= dim_size;
      r_stride   <= vec_stride;
      r_base     <= '0;
      r_mem_addr <= '0;
      r_widx     <= '0;
      r_vid      <= '0;
      r_acc      <= '0;
      r_list     <= '0;
      r_valid    <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          r_widx     <= r_widx + WCNT_W'(1);
          r_mem_addr <= r_base + ADDR_W'(r_widx) + ADDR_W'(1);
          r_acc      <= (r_widx == '0) ? 32'sd0 : r_acc + w_word_sum;
        end
        ST_DRAIN: r_acc <= r_acc + w_word_sum;
        ST_INSERT: begin
          r_list     <= w_list_ins;
          r_valid    <= w_valid_ins;
          r_vid      <= r_vid + 10'd1;
          r_base     <= r_base + r_stride;
          r_mem_addr <= r_base + r_stride;
          r_widx     <= '0;
        end
        default: ;
      endcase
    end
  end

  // Query buffer, writable only while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < QWORDS; i++) r_query[i] <= '0;
    end else if (q_wr_en && !r_busy && (32'(q_wr_addr) < QWORDS)) begin
      r_query[QIDX_W'(q_wr_addr)] <= q_wr_data;
    end
  end

  for (genvar g = 0; g < int'(K); g++) begin : g_out
    assign topk_score[SCORE_W*g +: SCORE_W] = r_list[g].score;
    assign topk_id[ID_W*g +: ID_W]          = r_list[g].id;
  end

  assign mem_addr   = r_mem_addr;
  assign topk_valid = r_valid;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_vector_topk_engine.sv
// Directed self-checking bench for vector_topk_engine with a synchronous-read memory model.
module tb_vector_topk_engine;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         clear;
  logic         start_search;
  logic [9:0]   vector_count;
  logic [7:0]   dim_size;
  logic [11:0]  vec_stride;
  logic         q_wr_en;
  logic [5:0]   q_wr_addr;
  logic [31:0]  q_wr_data;
  logic [11:0]  mem_addr;
  logic [31:0]  mem_data;
  logic [127:0] topk_score;
  logic [39:0]  topk_id;
  logic [2:0]   topk_valid;
  logic         busy;
  logic         done;
`ifdef VTOPK_THRESHOLD_EN
  logic signed [31:0] min_score;
`endif

  logic [31:0] mem [4096];
  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  bit saw_done;

  vector_topk_engine dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .start_search (start_search),
    .vector_count (vector_count),
    .dim_size     (dim_size),
    .vec_stride   (vec_stride),
    .q_wr_en      (q_wr_en),
    .q_wr_addr    (q_wr_addr),
    .q_wr_data    (q_wr_data),
`ifdef VTOPK_THRESHOLD_EN
    .min_score    (min_score),
`endif
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .topk_score   (topk_score),
    .topk_id      (topk_id),
    .topk_valid   (topk_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem[mem_addr];

  function automatic logic [127:0] pk_s(input int s0, input int s1, input int s2, input int s3);
    return {32'(s3), 32'(s2), 32'(s1), 32'(s0)};
  endfunction

  function automatic logic [39:0] pk_i(input int i0, input int i1, input int i2, input int i3);
    return {10'(i3), 10'(i2), 10'(i1), 10'(i0)};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = '0;
  endtask

  task automatic wq(input int a, input logic [31:0] d);
    @(negedge clk);
    q_wr_en = 1'b1; q_wr_addr = 6'(a); q_wr_data = d;
    @(negedge clk);
    q_wr_en = 1'b0;
  endtask

  // Start a search and count cycles until done; poke tries an ignored restart and query write.
  task automatic run_search(input int cnt, input int dim, input int stride, input bit poke,
                            output int cycles);
    @(negedge clk);
    vector_count = 10'(cnt); dim_size = 8'(dim); vec_stride = 12'(stride); start_search = 1'b1;
    @(posedge clk); #1;
    start_search = 1'b0;
    cycles = 1;
    check("busy_set", {127'd0, busy}, 128'd1);
    while (!done && cycles < 500) begin
      if (poke && cycles == 4) begin
        @(negedge clk);
        start_search = 1'b1; vector_count = 10'd1;
        q_wr_en = 1'b1; q_wr_addr = 6'd0; q_wr_data = 32'h7F7F7F7F;
      end
      @(posedge clk); #1;
      cycles++;
      if (poke && cycles == 5) begin
        start_search = 1'b0; q_wr_en = 1'b0;
      end
    end
    if (!done) check("done_timeout", {127'd0, done}, 128'd1);
  endtask

  task automatic check_end();
    @(posedge clk); #1;
    check("done_one_cycle", {127'd0, done}, 128'd0);
    check("busy_cleared", {127'd0, busy}, 128'd0);
  endtask

  task automatic load_scn1();
    clear_mem();
    mem[0] = 32'h0A0A0A0A; mem[1] = 32'h0A0A0A0A;
    mem[4] = 32'h01010101; mem[8] = 32'hF6F6F6F6;
    wq(0, 32'h0A0A0A0A);
    wq(1, 32'h0A0A0A0A);
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; start_search = 1'b0;
    vector_count = '0; dim_size = '0; vec_stride = '0;
    q_wr_en = 1'b0; q_wr_addr = '0; q_wr_data = '0;
`ifdef VTOPK_THRESHOLD_EN
    min_score = 32'sh80000000;
`endif
    clear_mem();
    #22;
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_done", {127'd0, done}, 128'd0);
    check("rst_valid", {125'd0, topk_valid}, 128'd0);
    check("rst_score", topk_score, 128'd0);
    check("rst_id", {88'd0, topk_id}, 128'd0);
    check("rst_addr", {116'd0, mem_addr}, 128'd0);
    @(negedge clk); reset_n = 1'b1;

    // Scenario 1: three 8-element vectors, mixed signs
    load_scn1();
    run_search(3, 8, 4, 1'b0, cyc);
    check("s1_cycles", 128'(cyc), 128'd13);
    check("s1_valid", {125'd0, topk_valid}, 128'd3);
    check("s1_score", topk_score, pk_s(800, 40, -400, 0));
    check("s1_id", {88'd0, topk_id}, {88'd0, pk_i(0, 1, 2, 0)});
    check_end();
    repeat (4) @(posedge clk);
    #1;
    check("s1_hold", topk_score, pk_s(800, 40, -400, 0));

`ifdef VTOPK_THRESHOLD_EN
    // Threshold 0 drops the negative score without changing timing
    @(negedge clk); min_score = 32'sd0;
    run_search(3, 8, 4, 1'b0, cyc);
    check("th_cycles", 128'(cyc), 128'd13);
    check("th_valid", {125'd0, topk_valid}, 128'd2);
    check("th_score", topk_score, pk_s(800, 40, 0, 0));
    check_end();
    @(negedge clk); min_score = 32'sh80000000;
`endif

    // Scenario 2: scores 1..6, K=4 keeps the top four; busy restart and query write ignored
    clear_mem();
    for (int v = 0; v < 6; v++) mem[v] = 32'(v + 1);
    wq(0, 32'h00000001);
    run_search(6, 4, 1, 1'b1, cyc);
    check("s2_cycles", 128'(cyc), 128'd19);
    check("s2_valid", {125'd0, topk_valid}, 128'd4);
    check("s2_score", topk_score, pk_s(6, 5, 4, 3));
    check("s2_id", {88'd0, topk_id}, {88'd0, pk_i(5, 4, 3, 2)});
    check_end();

    // Scenario 3: dim 5 masks lanes 5..7
    clear_mem();
    mem[0] = 32'h01010101; mem[1] = 32'h01010101;
    wq(0, 32'h01010101);
    wq(1, 32'h01010101);
    run_search(1, 5, 2, 1'b0, cyc);
    check("s3_cycles", 128'(cyc), 128'd5);
    check("s3_valid", {125'd0, topk_valid}, 128'd1);
    check("s3_score", topk_score, pk_s(5, 0, 0, 0));
    check_end();

    // Scenario 4: equal scores, lower id first
    clear_mem();
    mem[0] = 32'h0000000A; mem[3] = 32'h0000000A;
    wq(0, 32'h0000000A);
    run_search(2, 4, 3, 1'b0, cyc);
    check("s4_cycles", 128'(cyc), 128'd7);
    check("s4_valid", {125'd0, topk_valid}, 128'd2);
    check("s4_score", topk_score, pk_s(100, 100, 0, 0));
    check("s4_id", {88'd0, topk_id}, {88'd0, pk_i(0, 1, 0, 0)});
    check_end();

    // Scenario 5: clear after the first insert aborts silently
    load_scn1();
    @(negedge clk);
    vector_count = 10'd3; dim_size = 8'd8; vec_stride = 12'd4; start_search = 1'b1;
    @(posedge clk); #1;
    start_search = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("s5_partial_valid", {125'd0, topk_valid}, 128'd1);
    check("s5_partial_score", topk_score, pk_s(800, 0, 0, 0));
    @(negedge clk); clear = 1'b1;
    @(posedge clk); #1;
    check("s5_busy", {127'd0, busy}, 128'd0);
    check("s5_valid", {125'd0, topk_valid}, 128'd0);
    check("s5_score", topk_score, 128'd0);
    @(negedge clk); clear = 1'b0;
    saw_done = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("s5_no_done", {127'd0, saw_done}, 128'd0);

    // Scenario 6: async reset mid-search zeroes outputs and the query buffer
    @(negedge clk);
    vector_count = 10'd3; dim_size = 8'd8; vec_stride = 12'd4; start_search = 1'b1;
    @(posedge clk); #1;
    start_search = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("s6_busy", {127'd0, busy}, 128'd0);
    check("s6_done", {127'd0, done}, 128'd0);
    check("s6_valid", {125'd0, topk_valid}, 128'd0);
    check("s6_score", topk_score, 128'd0);
    check("s6_id", {88'd0, topk_id}, 128'd0);
    check("s6_addr", {116'd0, mem_addr}, 128'd0);
    @(negedge clk); reset_n = 1'b1;
    run_search(1, 8, 4, 1'b0, cyc);
    check("s6_post_cycles", 128'(cyc), 128'd5);
    check("s6_post_valid", {125'd0, topk_valid}, 128'd1);
    check("s6_post_score", topk_score, 128'd0);
    check_end();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vector_topk_engine.md
VECTOR_TOPK_ENGINE -- requirements
Module: vector_topk_engine

Interface
REQ-001 SHALL have parameter LANES, default 4: int8 lanes per memory word; word width is 8*LANES.
REQ-002 SHALL have parameter K, default 4: top-K list depth.
REQ-003 SHALL have parameter ADDR_W, default 12: memory address width.
REQ-004 SHALL have parameter QWORDS, default 64: query buffer depth in words.
REQ-005 SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous abort plus list flush.
- start_search  in  1  single-cycle start pulse.
- vector_count  in  10  number of vectors to scan.
- dim_size  in  8  elements per vector.
- vec_stride  in  ADDR_W  words between vector bases.
- q_wr_en  in  1  query buffer write strobe.
- q_wr_addr  in  6  query word index.
- q_wr_data  in  8*LANES  query word.
- mem_addr  out  ADDR_W  memory read address.
- mem_data  in  8*LANES  read data, valid 1 cycle after mem_addr.
- topk_score  out  32*K  signed scores; slot 0 (LSBs) holds the best.
- topk_id  out  10*K  vector ids, same slot order.
- topk_valid  out  3  number of filled slots.
- busy  out  1  search in progress.
- done  out  1  one-cycle pulse at search end.

Function
REQ-006 SHALL set W = ceil(dim_size/LANES), or W = 1 when dim_size = 0; vector v occupies words v*vec_stride .. v*vec_stride+W-1.
REQ-007 SHALL compute score = sum over lanes of signed(mem byte) * signed(query byte); lanes with element index >= dim_size contribute 0; result is sign-extended to 32 bits (no overflow possible).
REQ-008 FSM states SHALL be IDLE, FETCH, DRAIN, INSERT, DONE.
REQ-009 In IDLE, start_search SHALL latch all config inputs, empty the list, set busy, and enter FETCH; if vector_count = 0 it SHALL enter DONE instead.
REQ-010 FETCH SHALL issue one address per cycle for W cycles; DRAIN SHALL accumulate the final word; INSERT SHALL take 1 cycle. Each vector therefore costs W+2 cycles.
REQ-011 INSERT SHALL place the score in descending order; on equal scores, the earlier (lower) id ranks higher; when the list is full, a score not strictly greater than slot K-1 SHALL be dropped.
REQ-012 After the last INSERT, DONE SHALL pulse done for 1 cycle, clear busy, and return to IDLE; results SHALL hold until the next start or clear.
REQ-013 start_search while busy SHALL be ignored; q_wr_en while busy SHALL be ignored.
REQ-014 clear SHALL override start, return to IDLE, empty the list, drop busy, and generate no done pulse.
REQ-015 Unfilled slots SHALL read score 0 and id 0.

Reset
REQ-016 Asynchronous assertion of reset_n low SHALL force IDLE, busy = 0, done = 0, topk_valid = 0, all slots to 0, mem_addr = 0, and the query buffer to 0, regardless of state.

Configuration
REQ-017 With VTOPK_THRESHOLD_EN defined, a 32-bit signed input min_score SHALL exist, and a score < min_score SHALL be skipped in INSERT (cycle count unchanged). Without the macro, neither the port nor the logic SHALL exist.

Structure
REQ-018 Package vtopk_pkg SHALL hold the FSM state enum, the score/id widths (32/10), and the entry struct {score, id}.
REQ-019 Sorted insertion SHALL be sub-module vtopk_insert (combinational K-slot shift-insert).

Verification
REQ-020 The bench SHALL cover these scenarios:
- Query words 0x0A0A0A0A x2; dim 8; stride 4; count 3; mem[0..1]=0x0A0A0A0A, mem[4]=0x01010101, mem[8]=0xF6F6F6F6 -> ids 0,1,2; scores 800,40,-400; valid 3; done 13 cycles after start.
- 6 vectors scoring 1..6 with K=4 -> ids 5,4,3,2; scores 6,5,4,3; valid 4.
- dim 5 with all bytes 0x01 -> score 5 (lanes 5-7 masked).
- Two vectors, each scoring 100 -> lower id in slot 0.
- clear asserted mid-search -> busy 0 next cycle, valid 0, no done; reset_n low mid-search -> all outputs 0.
- VTOPK_THRESHOLD_EN, min_score 0, the scenario-1 data -> valid 2; -400 dropped.
